ramp_frame_checker: RTL and testbench

Receive-side checker for the ramp test stream driving the FFT datapath. Takes the 8-bit real/imag sample stream and its divided sample strobe, detects strobe edges, and frames samples between clear pulses. Checks each frame against a self-seeded modulo-256 ramp, counts mismatches, and reports pass/fail at end of frame. Sits at the far end of the stimulus path, as the loopback/sink check in bring-up builds.

---
 rtl/ramp_chk_pkg.sv | 14 +
 rtl/ramp_cap_ram.sv | 26 ++
 rtl/ramp_frame_checker.sv | 148 ++++++++++++++
 tb/tb_ramp_frame_checker.sv | 265 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/ramp_chk_pkg.sv
// rtl/ramp_chk_pkg.sv - shared types and constants for the ramp frame checker
package ramp_chk_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      SEED = 2'd1,
      RUN  = 2'd2,
      DONE = 2'd3
   } ramp_state_t;

   localparam int SAMPLE_W          = 8;
   localparam int DEFAULT_FRAME_LEN = 256;

endpackage

// File: rtl/ramp_cap_ram.sv
// rtl/ramp_cap_ram.sv - simple dual-port capture RAM, synchronous write, registered read
module ramp_cap_ram #(
   parameter int DEPTH = 256,
   parameter int WIDTH = 16
) (
   input  logic             clk,
   input  logic             we,
   input  logic [7:0]       waddr,
   input  logic [WIDTH-1:0] wdata,
   input  logic [7:0]       raddr,
   output logic [WIDTH-1:0] rdata
);

   logic [WIDTH-1:0] mem [DEPTH];

   // write port: store the accepted sample
   always_ff @(posedge clk) begin
      if (we) mem[waddr] <= wdata;
   end

   // read port: one cycle of latency
   always_ff @(posedge clk) begin
      rdata <= mem[raddr];
   end

endmodule

// File: rtl/ramp_frame_checker.sv
// rtl/ramp_frame_checker.sv - ramp stream frame checker; optional capture buffer under RAMP_CHK_CAPTURE_EN
module ramp_frame_checker
   import ramp_chk_pkg::*;
#(
   parameter int FRAME_LEN = DEFAULT_FRAME_LEN,
   parameter int ERR_W     = 9
) (
   input  logic                clk,
   input  logic                rst,
   input  logic [SAMPLE_W-1:0] in_real,
   input  logic [SAMPLE_W-1:0] in_imag,
   input  logic                in_strobe,
   input  logic                in_clr,
`ifdef RAMP_CHK_CAPTURE_EN
   input  logic [7:0]          cap_addr,
   output logic [15:0]         cap_data,
`endif
   output logic                busy,
   output logic [7:0]          sample_idx,
   output logic [ERR_W-1:0]    err_count,
   output logic                frame_done,
   output logic                pass
);

   localparam logic [8:0] LAST_IDX = 9'(FRAME_LEN);

   ramp_state_t         state, state_d;
   logic                strb_q;
   logic                accept;
   logic                mismatch;
   logic                last_sample;
   logic [SAMPLE_W-1:0] exp_real, exp_imag, exp_real_d, exp_imag_d;
   logic [7:0]          sample_idx_d;
   logic [ERR_W-1:0]    err_d;
   logic                pass_d, done_d, busy_d;

   assign accept      = in_strobe & ~strb_q;
   assign mismatch    = (in_real != exp_real) || (in_imag != exp_imag);
   assign last_sample = ({1'b0, sample_idx} + 9'd1) == LAST_IDX;

   // state register and strobe edge history; strobe history resets high so a
   // strobe already high at reset release is not taken as an edge
   always_ff @(posedge clk) begin
      if (rst) begin
         state  <= IDLE;
         strb_q <= 1'b1;
      end else begin
         state  <= state_d;
         strb_q <= in_strobe;
      end
   end

   // next-state: clear wins over everything, DONE restarts on the next edge
   always_comb begin
      state_d = state;
      if (in_clr) begin
         state_d = IDLE;
      end else begin
         case (state)
            IDLE:    state_d = SEED;
            SEED:    if (accept) state_d = RUN;
            RUN:     if (accept && last_sample) state_d = DONE;
            DONE:    if (accept) state_d = RUN;
            default: state_d = IDLE;
         endcase
      end
   end

   // next values of the checker datapath and registered outputs
   always_comb begin
      exp_real_d   = exp_real;
      exp_imag_d   = exp_imag;
      sample_idx_d = sample_idx;
      err_d        = err_count;
      pass_d       = pass;
      done_d       = 1'b0;
      if (in_clr) begin
         sample_idx_d = '0;
         err_d        = '0;
         pass_d       = 1'b0;
      end else if (accept) begin
         case (state)
            SEED, DONE: begin
               exp_real_d   = in_real + SAMPLE_W'(1);
               exp_imag_d   = in_imag + SAMPLE_W'(1);
               sample_idx_d = 8'd1;
               err_d        = '0;
               pass_d       = 1'b0;
            end
            RUN: begin
               exp_real_d   = exp_real + SAMPLE_W'(1);
               exp_imag_d   = exp_imag + SAMPLE_W'(1);
               sample_idx_d = sample_idx + 8'd1;
               if (mismatch && (err_count != '1)) err_d = err_count + ERR_W'(1);
               if (last_sample) begin
                  done_d = 1'b1;
                  pass_d = (err_d == '0);
               end
            end
            default: ;
         endcase
      end
      busy_d = (state_d == SEED) || (state_d == RUN);
   end

   // output and expectation registers
   always_ff @(posedge clk) begin
      if (rst) begin
         exp_real   <= '0;
         exp_imag   <= '0;
         sample_idx <= '0;
         err_count  <= '0;
         pass       <= 1'b0;
         frame_done <= 1'b0;
         busy       <= 1'b0;
      end else begin
         exp_real   <= exp_real_d;
         exp_imag   <= exp_imag_d;
         sample_idx <= sample_idx_d;
         err_count  <= err_d;
         pass       <= pass_d;
         frame_done <= done_d;
         busy       <= busy_d;
      end
   end

`ifdef RAMP_CHK_CAPTURE_EN
   logic       cap_we;
   logic [7:0] cap_waddr;

   // frame-start accepts land at index 0, running accepts at the current count
   assign cap_we    = accept && !in_clr && (state != IDLE);
   assign cap_waddr = (state == RUN) ? sample_idx : 8'd0;

   ramp_cap_ram #(
      .DEPTH (FRAME_LEN),
      .WIDTH (16)
   ) u_cap_ram (
      .clk   (clk),
      .we    (cap_we),
      .waddr (cap_waddr),
      .wdata ({in_real, in_imag}),
      .raddr (cap_addr),
      .rdata (cap_data)
   );
`endif

endmodule

// File: tb/tb_ramp_frame_checker.sv
// tb/tb_ramp_frame_checker.sv - self-checking bench for ramp_frame_checker
module tb_ramp_frame_checker;

   logic       clk = 1'b0;
   logic       rst;
   logic [7:0] in_real, in_imag;
   logic       in_strobe, in_clr;

   logic       busy, frame_done, pass;
   logic [7:0] sample_idx;
   logic [8:0] err_count;

   logic       s_busy, s_frame_done, s_pass;
   logic [7:0] s_sample_idx;
   logic [3:0] s_err_count;

   int vectors = 0;
   int miscompares = 0;
   int done_cnt = 0;
   int s_done_cnt = 0;

   logic [7:0] sr [256];
   logic [7:0] si [256];

   typedef struct {
      int seed_r;
      int seed_i;
      int bad_i0;   // imag-only corruption position, -1 none
      int bad_i1;
      int bad_b;    // real and imag corruption position
      int bad_r;    // real-only corruption position
      bit use_clr;
      int exp_err;
      bit exp_pass;
   } vec_t;

   vec_t vecs [6];

   always #5 clk = ~clk;

   ramp_frame_checker dut (
      .clk        (clk),
      .rst        (rst),
      .in_real    (in_real),
      .in_imag    (in_imag),
      .in_strobe  (in_strobe),
      .in_clr     (in_clr),
      .busy       (busy),
      .sample_idx (sample_idx),
      .err_count  (err_count),
      .frame_done (frame_done),
      .pass       (pass)
   );

   ramp_frame_checker #(.FRAME_LEN(32), .ERR_W(4)) dut_sat (
      .clk        (clk),
      .rst        (rst),
      .in_real    (in_real),
      .in_imag    (in_imag),
      .in_strobe  (in_strobe),
      .in_clr     (in_clr),
      .busy       (s_busy),
      .sample_idx (s_sample_idx),
      .err_count  (s_err_count),
      .frame_done (s_frame_done),
      .pass       (s_pass)
   );

   always @(negedge clk) begin
      if (frame_done) done_cnt++;
      if (s_frame_done) s_done_cnt++;
   end

   task automatic check(input string name, input int got, input int want);
      vectors++;
      if (got != want) begin
         miscompares++;
         $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, got, want, $time);
      end
   endtask

   task automatic send_sample(input logic [7:0] r, input logic [7:0] i);
      in_strobe = 1'b0;
      in_real   = r;
      in_imag   = i;
      repeat (2) @(posedge clk);
      #1;
      in_strobe = 1'b1;
      repeat (2) @(posedge clk);
      #1;
   endtask

   task automatic run_frame(input int n);
      for (int k = 0; k < n; k++) send_sample(sr[k], si[k]);
   endtask

   task automatic clr_pulse(input bit do_check);
      in_clr    = 1'b1;
      in_strobe = 1'b0;
      @(posedge clk);
      #1;
      if (do_check) begin
         check("clr_idx", sample_idx, 0);
         check("clr_err", err_count, 0);
         check("clr_busy", busy, 0);
         check("clr_pass", pass, 0);
      end
      @(posedge clk);
      #1;
      in_clr = 1'b0;
      repeat (2) @(posedge clk);
      #1;
   endtask

   task automatic fill_ramp(input int r0, input int i0);
      for (int k = 0; k < 256; k++) begin
         sr[k] = 8'((r0 + k) % 256);
         si[k] = 8'((i0 + k) % 256);
      end
   endtask

   // reference: every sample after the first must continue the ramp seeded by sample 0
   function automatic int model_errs(input int n, input int sat);
      int e = 0;
      for (int k = 1; k < n; k++) begin
         if (int'(sr[k]) != (int'(sr[0]) + k) % 256 || int'(si[k]) != (int'(si[0]) + k) % 256)
            e++;
      end
      return (e > sat) ? sat : e;
   endfunction

   task automatic check_frame(input string name, input int want_err, input int want_pass,
                              input int done_before);
      check({name, "_err"}, err_count, want_err);
      check({name, "_pass"}, pass, want_pass);
      check({name, "_idx"}, sample_idx, 0);
      check({name, "_busy"}, busy, 0);
      check({name, "_done"}, done_cnt - done_before, 1);
   endtask

   initial begin
      int d0;
      int e;
      vecs[0] = '{0,   0,   -1, -1, -1, -1,  1, 0,   1};
      vecs[1] = '{200, 200, -1, -1, -1, -1,  1, 0,   1};
      vecs[2] = '{0,   0,   10, 11, 50, -1,  1, 3,   0};
      vecs[3] = '{17,  99,  -1, -1, -1, -1,  0, 0,   1};
      vecs[4] = '{255, 3,   -1, -1, -1, 255, 0, 1,   0};
      vecs[5] = '{40,  40,  -1, -1, -1, 0,   1, 255, 0};

      rst       = 1'b1;
      in_clr    = 1'b0;
      in_strobe = 1'b1;
      in_real   = 8'd0;
      in_imag   = 8'd0;
      repeat (3) @(posedge clk);
      #1;
      check("rst_idx", sample_idx, 0);
      check("rst_err", err_count, 0);
      check("rst_busy", busy, 0);
      check("rst_pass", pass, 0);
      check("rst_done", frame_done, 0);

      // strobe held high across reset release must not count as an edge
      rst = 1'b0;
      repeat (6) @(posedge clk);
      #1;
      check("hi_strobe_idx", sample_idx, 0);
      check("hi_strobe_busy", busy, 1);
      send_sample(8'd5, 8'd5);
      check("first_edge_idx", sample_idx, 1);
      send_sample(8'd6, 8'd6);
      check("second_edge_idx", sample_idx, 2);
      clr_pulse(1'b1);

      for (int v = 0; v < 6; v++) begin
         if (vecs[v].use_clr) clr_pulse(1'b0);
         fill_ramp(vecs[v].seed_r, vecs[v].seed_i);
         if (vecs[v].bad_i0 >= 0) si[vecs[v].bad_i0] ^= 8'h5a;
         if (vecs[v].bad_i1 >= 0) si[vecs[v].bad_i1] ^= 8'h21;
         if (vecs[v].bad_b  >= 0) begin
            sr[vecs[v].bad_b] ^= 8'h0f;
            si[vecs[v].bad_b] ^= 8'hf0;
         end
         if (vecs[v].bad_r  >= 0) sr[vecs[v].bad_r] ^= 8'h5a;
         d0 = done_cnt;
         run_frame(255);
         check($sformatf("vec%0d_pre_idx", v), sample_idx, 255);
         check($sformatf("vec%0d_pre_done", v), done_cnt - d0, 0);
         send_sample(sr[255], si[255]);
         check_frame($sformatf("vec%0d", v), vecs[v].exp_err, vecs[v].exp_pass, d0);
      end

      // mid-frame abort with a coincident strobe edge
      clr_pulse(1'b0);
      fill_ramp(0, 0);
      d0 = done_cnt;
      run_frame(100);
      check("abort_pre_idx", sample_idx, 100);
      in_strobe = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      in_real   = 8'd100;
      in_imag   = 8'd100;
      in_strobe = 1'b1;
      in_clr    = 1'b1;
      @(posedge clk);
      #1;
      check("abort_idx", sample_idx, 0);
      check("abort_err", err_count, 0);
      check("abort_busy", busy, 0);
      in_clr = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      check("abort_idle_idx", sample_idx, 0);
      check("abort_done", done_cnt - d0, 0);
      fill_ramp(9, 130);
      d0 = done_cnt;
      run_frame(256);
      check_frame("after_abort", 0, 1, d0);

      // randomized frames against the ramp model
      for (int n = 0; n < 4; n++) begin
         int nbad;
         int pos;
         if ($urandom_range(0, 1) == 1) clr_pulse(1'b0);
         fill_ramp(int'($urandom_range(0, 255)), int'($urandom_range(0, 255)));
         nbad = int'($urandom_range(0, 4));
         for (int b = 0; b < nbad; b++) begin
            pos = int'($urandom_range(1, 255));
            case ($urandom_range(0, 2))
               0: sr[pos] ^= 8'(1 + $urandom_range(0, 254));
               1: si[pos] ^= 8'(1 + $urandom_range(0, 254));
               default: begin
                  sr[pos] ^= 8'(1 + $urandom_range(0, 254));
                  si[pos] ^= 8'(1 + $urandom_range(0, 254));
               end
            endcase
         end
         e  = model_errs(256, 511);
         d0 = done_cnt;
         run_frame(256);
         check_frame($sformatf("rand%0d", n), e, (e == 0) ? 1 : 0, d0);
      end

      // saturation on the short instance with random data
      clr_pulse(1'b0);
      for (int k = 0; k < 32; k++) begin
         sr[k] = 8'($urandom_range(0, 255));
         si[k] = 8'($urandom_range(0, 255));
      end
      d0 = s_done_cnt;
      run_frame(32);
      check("sat_err", s_err_count, model_errs(32, 15));
      check("sat_pass", s_pass, (model_errs(32, 15) == 0) ? 1 : 0);
      check("sat_idx", s_sample_idx, 32);
      check("sat_done", s_done_cnt - d0, 1);
      check("sat_wide_err", err_count, model_errs(32, 511));
      check("sat_wide_idx", sample_idx, 32);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
